// File: rtl/cam_multi_match_if.sv
// Request/result bundle between the key-lookup front end (master) and the CAM (slave).
interface cam_multi_match_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
);
    logic                  wr_en;
    logic                  wr_op;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] wr_mask;
    logic                  flush;
    logic                  search_en;
    logic [DATA_WIDTH-1:0] search_key;
    logic                  busy;
    logic                  match_valid;
    logic                  match;
    logic                  multi_match;
    logic [ADDR_WIDTH-1:0] match_addr;
    logic [ADDR_WIDTH:0]   occupancy;

    modport master (
        output wr_en, wr_op, wr_addr, wr_data, wr_mask, flush, search_en, search_key,
        input  busy, match_valid, match, multi_match, match_addr, occupancy
    );

    modport slave (
        input  wr_en, wr_op, wr_addr, wr_data, wr_mask, flush, search_en, search_key,
        output busy, match_valid, match, multi_match, match_addr, occupancy
    );
endinterface

// File: rtl/cam_multi_match.sv
// CAM with insert/delete/flush and registered lowest-index search plus multi-match flag.
// Optional ternary (per-entry care mask) compare is enabled by defining CAM_TERNARY_EN.
module cam_multi_match #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    cam_multi_match_if.slave bus,
    output logic [1:0]       state_dbg
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [ADDR_WIDTH-1:0] flush_cnt_q;
    logic [ADDR_WIDTH:0]   occ_q;
    logic [DEPTH-1:0]      hit_d, hit_q;
    logic                  search_pend_q;
    logic                  match_valid_q, match_q, multi_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] enc_addr;
    logic                  enc_any, enc_multi;
    logic                  flush_acc, wr_acc, srch_acc;

    // Handshake: a request is taken on a rising edge where it is high and busy is low;
    // flush beats wr_en beats search_en, and anything not taken is simply dropped.
    always_comb begin
        state_d   = state_q;
        flush_acc = 1'b0;
        wr_acc    = 1'b0;
        srch_acc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    flush_acc = 1'b1;
                    state_d   = FLUSH;
                end else if (bus.wr_en) begin
                    wr_acc  = 1'b1;
                    state_d = WRITE;
                end else if (bus.search_en) begin
                    srch_acc = 1'b1;
                end
            end
            WRITE: state_d = IDLE;
            FLUSH: if (&flush_cnt_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef CAM_TERNARY_EN
    logic [DATA_WIDTH-1:0] mask_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_acc && bus.wr_op) mask_mem[bus.wr_addr] <= bus.wr_mask;
    end

    always_comb begin
        hit_d = '0;
        for (int i = 0; i < DEPTH; i++)
            hit_d[i] = valid_q[i] && (((mem[i] ^ bus.search_key) & mask_mem[i]) == '0);
    end
`else
    logic unused_mask;
    assign unused_mask = ^bus.wr_mask;

    always_comb begin
        hit_d = '0;
        for (int i = 0; i < DEPTH; i++)
            hit_d[i] = valid_q[i] && (mem[i] == bus.search_key);
    end
`endif

    // Entry payload carries no reset; only the valid bits define table contents.
    always_ff @(posedge clk) begin
        if (wr_acc && bus.wr_op) mem[bus.wr_addr] <= bus.wr_data;
    end

    always_comb begin
        enc_addr  = '0;
        enc_any   = 1'b0;
        enc_multi = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (hit_q[i]) enc_addr = ADDR_WIDTH'(i);
        for (int i = 0; i < DEPTH; i++) begin
            if (hit_q[i]) begin
                if (enc_any) enc_multi = 1'b1;
                enc_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            flush_cnt_q   <= '0;
            occ_q         <= '0;
            hit_q         <= '0;
            search_pend_q <= 1'b0;
            match_valid_q <= 1'b0;
            match_q       <= 1'b0;
            multi_q       <= 1'b0;
            addr_q        <= '0;
        end else begin
            state_q       <= state_d;
            search_pend_q <= srch_acc;
            match_valid_q <= search_pend_q;
            if (srch_acc) hit_q <= hit_d;
            if (search_pend_q) begin
                match_q <= enc_any;
                multi_q <= enc_multi;
                addr_q  <= enc_addr;
            end

            if (flush_acc) begin
                flush_cnt_q <= '0;
            end else if (state_q == FLUSH) begin
                valid_q[flush_cnt_q] <= 1'b0;
                flush_cnt_q          <= flush_cnt_q + 1'b1;
                if (valid_q[flush_cnt_q]) occ_q <= occ_q - 1'b1;
            end

            if (wr_acc) begin
                valid_q[bus.wr_addr] <= bus.wr_op;
                if (bus.wr_op && !valid_q[bus.wr_addr])
                    occ_q <= occ_q + 1'b1;
                else if (!bus.wr_op && valid_q[bus.wr_addr])
                    occ_q <= occ_q - 1'b1;
            end
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.match_valid = match_valid_q;
    assign bus.match       = match_q;
    assign bus.multi_match = multi_q;
    assign bus.match_addr  = addr_q;
    assign bus.occupancy   = occ_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_cam_multi_match.sv
// Directed bench for cam_multi_match at DATA_WIDTH=16, ADDR_WIDTH=3 (exact or ternary build).
module tb_cam_multi_match;
    localparam int DW = 16;
    localparam int AW = 3;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
    int         errors = 0;
    int         checks = 0;

    cam_multi_match_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    cam_multi_match #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic op, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [DW-1:0] mask);
        bus.wr_en   = 1'b1;
        bus.wr_op   = op;
        bus.wr_addr = addr;
        bus.wr_data = data;
        bus.wr_mask = mask;
        tick();
        bus.wr_en = 1'b0;
        check("write_busy", 32'(bus.busy), 32'd1);
        tick();
        check("write_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_search(input string tag, input logic [DW-1:0] key, input logic exp_match,
                             input logic exp_multi, input logic [AW-1:0] exp_addr);
        bus.search_en  = 1'b1;
        bus.search_key = key;
        tick();
        bus.search_en = 1'b0;
        check({tag, "_mv_lat"}, 32'(bus.match_valid), 32'd0);
        tick();
        check({tag, "_mv"}, 32'(bus.match_valid), 32'd1);
        check({tag, "_match"}, 32'(bus.match), 32'(exp_match));
        check({tag, "_multi"}, 32'(bus.multi_match), 32'(exp_multi));
        check({tag, "_addr"}, 32'(bus.match_addr), 32'(exp_addr));
        tick();
        check({tag, "_mv_end"}, 32'(bus.match_valid), 32'd0);
        check({tag, "_hold"}, 32'(bus.match_addr), 32'(exp_addr));
    endtask

    initial begin
        rst = 1'b0;
        bus.wr_en = 1'b0; bus.wr_op = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.wr_mask = '1; bus.flush = 1'b0; bus.search_en = 1'b0; bus.search_key = '0;
        tick();
        tick();
        rst = 1'b1;

        // Reset state
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_mv", 32'(bus.match_valid), 32'd0);
        check("rst_match", 32'(bus.match), 32'd0);
        check("rst_multi", 32'(bus.multi_match), 32'd0);
        check("rst_addr", 32'(bus.match_addr), 32'd0);
        check("rst_occ", 32'(bus.occupancy), 32'd0);
        do_search("empty", 16'h0000, 1'b0, 1'b0, 3'd0);

        // Single insert
        do_write(1'b1, 3'd3, 16'hBEEF, 16'hFFFF);
        check("occ_1", 32'(bus.occupancy), 32'd1);
        do_search("one", 16'hBEEF, 1'b1, 1'b0, 3'd3);

        // Multi-match, delete, no-op delete, overwrite of a valid entry
        do_write(1'b1, 3'd5, 16'hBEEF, 16'hFFFF);
        do_write(1'b1, 3'd1, 16'hBEEF, 16'hFFFF);
        check("occ_3", 32'(bus.occupancy), 32'd3);
        do_search("three", 16'hBEEF, 1'b1, 1'b1, 3'd1);
        do_write(1'b0, 3'd1, 16'h0000, 16'hFFFF);
        check("occ_del", 32'(bus.occupancy), 32'd2);
        do_search("after_del", 16'hBEEF, 1'b1, 1'b1, 3'd3);
        do_write(1'b0, 3'd1, 16'h0000, 16'hFFFF);
        check("occ_del_invalid", 32'(bus.occupancy), 32'd2);
        do_write(1'b1, 3'd5, 16'h5555, 16'hFFFF);
        check("occ_overwrite", 32'(bus.occupancy), 32'd2);
        do_search("after_ovw", 16'hBEEF, 1'b1, 1'b0, 3'd3);

        // Fill the table, probe both end entries, overwrite while full
        for (int i = 0; i < 8; i++) do_write(1'b1, 3'(i), 16'h1000 + 16'(i), 16'hFFFF);
        check("occ_full", 32'(bus.occupancy), 32'd8);
        do_search("top", 16'h1007, 1'b1, 1'b0, 3'd7);
        do_search("bottom", 16'h1000, 1'b1, 1'b0, 3'd0);
        do_write(1'b1, 3'd0, 16'h1007, 16'hFFFF);
        check("occ_full_ovw", 32'(bus.occupancy), 32'd8);
        do_search("full_ovw", 16'h1007, 1'b1, 1'b1, 3'd0);

        // Flush: busy for exactly 8 cycles, occupancy counting down
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_occ_start", 32'(bus.occupancy), 32'd8);
        for (int k = 1; k <= 8; k++) begin
            check("flush_busy", 32'(bus.busy), 32'd1);
            tick();
            check("flush_occ", 32'(bus.occupancy), 32'(8 - k));
        end
        check("flush_done", 32'(bus.busy), 32'd0);
        do_search("post_flush", 16'h1003, 1'b0, 1'b0, 3'd0);

        // Simultaneous flush/write/search: only the flush acts
        do_write(1'b1, 3'd2, 16'hAAAA, 16'hFFFF);
        bus.flush = 1'b1;
        bus.wr_en = 1'b1; bus.wr_op = 1'b1; bus.wr_addr = 3'd4; bus.wr_data = 16'hBBBB;
        bus.search_en = 1'b1; bus.search_key = 16'hAAAA;
        tick();
        bus.flush = 1'b0; bus.wr_en = 1'b0; bus.search_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("prio_busy", 32'(bus.busy), 32'd1);
            tick();
            check("prio_no_mv", 32'(bus.match_valid), 32'd0);
        end
        check("prio_idle", 32'(bus.busy), 32'd0);
        check("prio_occ", 32'(bus.occupancy), 32'd0);
        do_search("prio_dropped_wr", 16'hBBBB, 1'b0, 1'b0, 3'd0);

        // Write request held during WRITE is ignored
        bus.wr_en = 1'b1; bus.wr_op = 1'b1; bus.wr_addr = 3'd6; bus.wr_data = 16'hCCCC;
        tick();
        bus.wr_addr = 3'd7; bus.wr_data = 16'hDDDD;
        check("busy_wr_busy", 32'(bus.busy), 32'd1);
        tick();
        bus.wr_en = 1'b0;
        check("busy_wr_idle", 32'(bus.busy), 32'd0);
        check("busy_wr_occ", 32'(bus.occupancy), 32'd1);
        do_search("busy_wr_ignored", 16'hDDDD, 1'b0, 1'b0, 3'd0);
        do_search("busy_wr_first", 16'hCCCC, 1'b1, 1'b0, 3'd6);

        // Masked entry: ternary build treats 0xFF00 as care bits, exact build ignores the mask
        do_write(1'b1, 3'd2, 16'h12AB, 16'hFF00);
        check("mask_occ", 32'(bus.occupancy), 32'd2);
`ifdef CAM_TERNARY_EN
        do_search("tern_hit", 16'h1234, 1'b1, 1'b0, 3'd2);
        do_search("tern_miss", 16'h1334, 1'b0, 1'b0, 3'd0);
        do_write(1'b1, 3'd0, 16'h0F0F, 16'h0000);
        do_search("tern_wild", 16'hCCCC, 1'b1, 1'b1, 3'd0);
`else
        do_search("exact_miss", 16'h1234, 1'b0, 1'b0, 3'd0);
        do_search("exact_hit", 16'h12AB, 1'b1, 1'b0, 3'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
